stamp_sig_accum: RTL

STAMP_SIG_ACCUM -- requirements
Module: stamp_sig_accum

---
 rtl/stamp_sig_accum.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stamp_sig_accum.sv
// Signature accumulator for an upstream stamp stage: discards SKIP pipeline-flush
// samples, then compresses WINDOW accepted samples into a 32-bit MISR and a 40-bit wrapping sum.
module stamp_sig_accum #(
  parameter int unsigned WINDOW       = 512,
  parameter int unsigned SKIP         = 4,
  parameter logic [31:0] MISR_POLY    = 32'h04C11DB7,
  parameter logic [31:0] EXPECTED_SIG = 32'h00000000,
  parameter bit          CHECK_EN     = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ena,
  input  logic [31:0] i_data,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_sig,
  output logic [39:0] o_sum,
  output logic        o_pass
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  SKIP_L = 5'(SKIP);
  localparam logic [16:0] WIN_L  = 17'(WINDOW);

  // One MISR shift-and-fold step with the configured feedback polynomial.
  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] din);
    logic [31:0] fb;
    fb = sig[31] ? MISR_POLY : 32'h00000000;
    return ({sig[30:0], 1'b0} ^ fb) ^ din;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  skip_cnt_q, skip_cnt_d;
  logic [15:0] samp_cnt_q, samp_cnt_d;
  logic [31:0] sig_q, sig_d;
  logic [39:0] sum_q, sum_d;
  logic [31:0] out_sig_q, out_sig_d;
  logic [39:0] out_sum_q, out_sum_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] sig_step_s;
  logic [39:0] sum_step_s;
  logic        skip_last_s;
  logic        win_last_s;

  assign sig_step_s  = misr_step(sig_q, i_data);
  assign sum_step_s  = sum_q + {8'd0, i_data};
  assign skip_last_s = (({1'b0, skip_cnt_q} + 5'd1) == SKIP_L);
  assign win_last_s  = (({1'b0, samp_cnt_q} + 17'd1) == WIN_L);

  // Next-state and datapath update; every target keeps its value unless a case overrides it.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    samp_cnt_d = samp_cnt_q;
    sig_d      = sig_q;
    sum_d      = sum_q;
    out_sig_d  = out_sig_q;
    out_sum_d  = out_sum_q;
    pass_d     = pass_q;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d    = (SKIP_L != 5'd0) ? FLUSH : RUN;
          skip_cnt_d = 4'd0;
          samp_cnt_d = 16'd0;
          sig_d      = 32'h00000000;
          sum_d      = 40'h0000000000;
        end else begin
          state_d = state_q;
        end
      end

      FLUSH: begin
        if (i_ena) begin
          skip_cnt_d = skip_cnt_q + 4'd1;
          if (skip_last_s) begin
            state_d = RUN;
          end else begin
            state_d = FLUSH;
          end
        end else begin
          state_d = FLUSH;
        end
      end

      RUN: begin
        if (i_ena) begin
          sig_d      = sig_step_s;
          sum_d      = sum_step_s;
          samp_cnt_d = samp_cnt_q + 16'd1;
          if (win_last_s) begin
            state_d   = DONE;
            out_sig_d = sig_step_s;
            out_sum_d = sum_step_s;
            if (CHECK_EN) begin
              pass_d = (sig_step_s == EXPECTED_SIG);
            end else begin
              pass_d = 1'b1;
            end
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FLUSH) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, counters, working accumulators and latched results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      skip_cnt_q <= 4'd0;
      samp_cnt_q <= 16'd0;
      sig_q      <= 32'h00000000;
      sum_q      <= 40'h0000000000;
      out_sig_q  <= 32'h00000000;
      out_sum_q  <= 40'h0000000000;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      sig_q      <= sig_d;
      sum_q      <= sum_d;
      out_sig_q  <= out_sig_d;
      out_sum_q  <= out_sum_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_sig  = out_sig_q;
  assign o_sum  = out_sum_q;
  assign o_pass = pass_q;

endmodule
